// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the generic pipeline-stage
//               register: skid occupancy states and per-boundary NOP payloads.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // Occupancy of a stage with a skid entry: nothing held, main only, main+skid
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // Bubble encodings loaded on reset/flush at each pipeline boundary
   localparam logic [15:0] c_NOP_IF_ID  = 16'h0000;
   localparam logic [15:0] c_NOP_ID_EX  = 16'h0013;
   localparam logic [15:0] c_NOP_EX_MEM = 16'h0000;
   localparam logic [15:0] c_NOP_MEM_WB = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value; cleared only
//               by synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: hold once every bit is set so the counter never wraps
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_hs
// Description : Parametrised pipeline-stage register with valid/ready
//               handshake, stall, flush, optional 2-entry skid buffer and a
//               saturating count of cycles the output was held back.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W  = 16,
   parameter logic [DATA_W-1:0] RST_VAL = '0,
   parameter int unsigned       SKID    = 1,
   parameter int unsigned       CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic acc;
   logic pop;

   assign acc = in_valid & in_ready;
   assign pop = out_valid & out_ready & ~stall;

   if (SKID != 0) begin : g_skid
      occ_e              state_q;
      logic              valid_q;
      logic              skid_free_q;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] skid_q;

      // Ready comes only from a flop (and flush), never from out_ready
      assign in_ready  = skid_free_q & ~flush;
      assign out_valid = valid_q;
      assign out_data  = main_q;

      // Occupancy FSM; the skid entry is always younger than main
      always_ff @(posedge clk) begin
         if (rst || flush) begin
            state_q     <= OCC_EMPTY;
            valid_q     <= 1'b0;
            skid_free_q <= 1'b1;
            main_q      <= RST_VAL;
            skid_q      <= RST_VAL;
         end else begin
            case (state_q)
               OCC_EMPTY: begin
                  if (acc) begin
                     state_q <= OCC_ONE;
                     valid_q <= 1'b1;
                     main_q  <= in_data;
                  end
               end
               OCC_ONE: begin
                  if (acc && pop) begin
                     main_q <= in_data;
                  end else if (acc) begin
                     state_q     <= OCC_FULL;
                     skid_free_q <= 1'b0;
                     skid_q      <= in_data;
                  end else if (pop) begin
                     state_q <= OCC_EMPTY;
                     valid_q <= 1'b0;
                     main_q  <= RST_VAL;
                  end
               end
               OCC_FULL: begin
                  if (pop) begin
                     state_q     <= OCC_ONE;
                     skid_free_q <= 1'b1;
                     main_q      <= skid_q;
                     skid_q      <= RST_VAL;
                  end
               end
               default: begin
                  state_q     <= OCC_EMPTY;
                  valid_q     <= 1'b0;
                  skid_free_q <= 1'b1;
                  main_q      <= RST_VAL;
                  skid_q      <= RST_VAL;
               end
            endcase
         end
      end
   end else begin : g_noskid
      logic              valid_q;
      logic [DATA_W-1:0] data_q;

      // Accept when empty or when the held entry leaves this same cycle
      assign in_ready  = ~flush & (~valid_q | (out_ready & ~stall));
      assign out_valid = valid_q;
      assign out_data  = data_q;

      // Single entry: load on accept, return to the bubble value on drain
      always_ff @(posedge clk) begin
         if (rst || flush) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
         end else if (acc) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
         end else if (pop) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
         end
      end
   end

   // Held-back cycles survive flush; only reset clears them
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (out_valid & ~pop),
      .cnt_o (stall_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_hs
// Description : Scoreboard bench for pipe_stage_hs. Two instances share the
//               stimulus: k=0 is SKID=1/CNT_W=8, k=1 is SKID=0/CNT_W=2.
//               Each has a queue of accepted payloads as its reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

   localparam logic [15:0] RV = 16'hC0DE;

   logic        clk;
   logic        rst, flush, stall, in_valid, out_ready;
   logic [15:0] in_data;

   logic        in_ready_a, out_valid_a;
   logic [15:0] out_data_a;
   logic [7:0]  cnt_a;
   logic        in_ready_b, out_valid_b;
   logic [15:0] out_data_b;
   logic [1:0]  cnt_b;

   pipe_stage_hs #(.DATA_W(16), .RST_VAL(RV), .SKID(1), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .stall_cnt(cnt_a)
   );

   pipe_stage_hs #(.DATA_W(16), .RST_VAL(RV), .SKID(0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .stall_cnt(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   int unsigned cnt_m[2];
   logic        exp_rdy[2];
   logic        armed = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic int q_size(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [15:0] q_front(input int k);
      return (k == 0) ? q0[0] : q1[0];
   endfunction

   task automatic q_pop(input int k);
      if (k == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic q_push(input int k, input logic [15:0] d);
      if (k == 0) q0.push_back(d);
      else        q1.push_back(d);
   endtask

   task automatic q_clear(input int k);
      if (k == 0) q0.delete();
      else        q1.delete();
   endtask

   task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[k=%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
      end
   endtask

   // Output monitor for one instance: compare against the queue head, then
   // retire the entry if the downstream takes it this cycle
   task automatic mon(input int k, input logic v, input logic [15:0] d,
                      input logic r, input logic [31:0] c);
      logic        ev;
      logic [15:0] ed;
      logic        popm;
      int unsigned cmax;
      ev   = (q_size(k) != 0);
      ed   = ev ? q_front(k) : RV;
      cmax = (k == 0) ? 255 : 3;
      if (k == 0) exp_rdy[k] = !flush && (q_size(k) < 2);
      else        exp_rdy[k] = !flush && (!ev || (out_ready && !stall));
      if (armed) begin
         cmp("out_valid", k, 32'(v), 32'(ev));
         cmp("out_data",  k, 32'(d), 32'(ed));
         cmp("in_ready",  k, 32'(r), 32'(exp_rdy[k]));
         cmp("stall_cnt", k, c, cnt_m[k]);
      end
      popm = ev && out_ready && !stall;
      if (rst) cnt_m[k] = 0;
      else if (ev && !popm && cnt_m[k] < cmax) cnt_m[k] = cnt_m[k] + 1;
      if (popm && !rst) q_pop(k);
   endtask

   always @(negedge clk) begin
      mon(0, out_valid_a, out_data_a, in_ready_a, 32'(cnt_a));
      mon(1, out_valid_b, out_data_b, in_ready_b, 32'(cnt_b));
      if (rst) armed = 1'b1;
   end

   // One stimulus cycle; accepted payloads are pushed as expected outputs
   task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy,
                      input logic st, input logic fl, input logic rs);
      in_valid = iv; in_data = d; out_ready = ordy;
      stall = st; flush = fl; rst = rs;
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         if (rs || fl)              q_clear(k);
         else if (iv && exp_rdy[k]) q_push(k, d);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; in_data = '0;
      cnt_m[0] = 0; cnt_m[1] = 0; exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0;
      @(posedge clk); #1;

      // Reset held for two clocks
      cyc(0, 16'h0, 0, 0, 0, 1);
      cyc(0, 16'h0, 0, 0, 0, 1);

      // In-order stream at full rate
      for (int i = 1; i <= 16; i++) cyc(1, 16'(i), 1, 0, 0, 0);
      repeat (2) cyc(0, 16'h0, 1, 0, 0, 0);

      // Back-pressure into the skid entry, then release
      cyc(1, 16'hAAAA, 1, 0, 0, 0);
      cyc(1, 16'hBBBB, 0, 0, 0, 0);
      repeat (2) cyc(0, 16'h0, 0, 0, 0, 0);
      repeat (3) cyc(0, 16'h0, 1, 0, 0, 0);

      // Stall with a live entry; the 2-bit counter saturates
      cyc(0, 16'h0, 0, 0, 0, 1);
      cyc(1, 16'h1234, 1, 0, 0, 0);
      repeat (6) cyc(0, 16'h0, 1, 1, 0, 0);
      repeat (2) cyc(0, 16'h0, 1, 0, 0, 0);

      // Flush while full; the input offered during flush must vanish
      cyc(1, 16'h5555, 0, 0, 0, 0);
      cyc(1, 16'h6666, 0, 0, 0, 0);
      cyc(1, 16'h7777, 1, 0, 1, 0);
      repeat (3) cyc(0, 16'h0, 1, 0, 0, 0);

      // Reset while full
      cyc(1, 16'h8888, 0, 0, 0, 0);
      cyc(1, 16'h9999, 0, 0, 0, 0);
      cyc(1, 16'hAAAB, 0, 0, 0, 1);
      repeat (2) cyc(0, 16'h0, 1, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(99) < 70) ? 1'b1 : 1'b0,
             16'($urandom),
             ($urandom_range(99) < 60) ? 1'b1 : 1'b0,
             ($urandom_range(99) < 15) ? 1'b1 : 1'b0,
             ($urandom_range(99) < 3)  ? 1'b1 : 1'b0,
             ($urandom_range(199) < 1) ? 1'b1 : 1'b0);
      end

      // Bounded drain; anything still queued was lost by the DUT
      for (int i = 0; i < 20; i++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         cyc(0, 16'h0, 1, 0, 0, 0);
      end
      cmp("drained", 0, 32'(q0.size()), 32'd0);
      cmp("drained", 1, 32'(q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
